// File: rtl/tm_argmax_sequencer_if.sv
// Single-beat AXI-Stream result channel used by tm_argmax_sequencer.
interface tm_argmax_sequencer_if #(
    parameter int unsigned TDATA_WIDTH = 64
) ();
    logic                   tvalid;
    logic                   tready;
    logic [TDATA_WIDTH-1:0] tdata;
    logic                   tlast;

    modport master (output tvalid, output tdata, output tlast, input tready);
    modport slave  (input tvalid, input tdata, input tlast, output tready);
endinterface

// File: rtl/tm_argmax_sequencer.sv
// Time-multiplexed argmax over Tsetlin Machine class sums: one signed compare
// per cycle, result index delivered as a single AXI-Stream beat.
module tm_argmax_sequencer #(
    parameter int unsigned CLASS_NUM              = 10,
    parameter int unsigned WEIGHT_LENGTH          = 14,
    parameter int unsigned C_M00_AXIS_TDATA_WIDTH = 64,
    parameter int unsigned INDEX_LENGTH           = (CLASS_NUM > 1) ? $clog2(CLASS_NUM) : 1,
    parameter int unsigned DROP_CNT_WIDTH         = 8
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic signed [WEIGHT_LENGTH-1:0] c_sum [CLASS_NUM-1:0],
    input  logic                            its_business_time,
    tm_argmax_sequencer_if.master           m00_axis,
    output logic signed [WEIGHT_LENGTH-1:0] max_sum,
    output logic                            busy,
    output logic [DROP_CNT_WIDTH-1:0]       drop_cnt
);

    typedef enum logic [1:0] {IDLE, SCAN, OUT} state_t;

    localparam logic [INDEX_LENGTH-1:0] LAST_IDX = INDEX_LENGTH'(CLASS_NUM - 1);

    state_t                            state;
    logic                              prev;
    logic signed [WEIGHT_LENGTH-1:0]   sums_q [CLASS_NUM-1:0];
    logic signed [WEIGHT_LENGTH-1:0]   best;
    logic [INDEX_LENGTH-1:0]           best_idx;
    logic [INDEX_LENGTH-1:0]           ptr;
    logic                              tvalid_q;
    logic [C_M00_AXIS_TDATA_WIDTH-1:0] tdata_q;

    logic                              trig;
    logic signed [WEIGHT_LENGTH-1:0]   scan_best;
    logic [INDEX_LENGTH-1:0]           scan_idx;

    assign trig            = its_business_time & ~prev;
    assign m00_axis.tvalid = tvalid_q;
    assign m00_axis.tlast  = tvalid_q;
    assign m00_axis.tdata  = tdata_q;

    // Strict greater-than keeps the earlier index on ties.
    always_comb begin
        scan_best = best;
        scan_idx  = best_idx;
        if (sums_q[ptr] > best) begin
            scan_best = sums_q[ptr];
            scan_idx  = ptr;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            prev     <= 1'b0;
            sums_q   <= '{default: '0};
            best     <= '0;
            best_idx <= '0;
            ptr      <= '0;
            tvalid_q <= 1'b0;
            tdata_q  <= '0;
            max_sum  <= '0;
            busy     <= 1'b0;
            drop_cnt <= '0;
        end else begin
            prev <= its_business_time;

            if (trig && state != IDLE && drop_cnt != '1)
                drop_cnt <= drop_cnt + 1'b1;

            case (state)
                IDLE: begin
                    if (trig) begin
                        sums_q   <= c_sum;
                        best     <= c_sum[0];
                        best_idx <= '0;
                        ptr      <= INDEX_LENGTH'(1);
                        busy     <= 1'b1;
                        if (CLASS_NUM > 1) begin
                            state <= SCAN;
                        end else begin
                            state    <= OUT;
                            tvalid_q <= 1'b1;
                            tdata_q  <= '0;
                            max_sum  <= c_sum[0];
                        end
                    end
                end
                SCAN: begin
                    best     <= scan_best;
                    best_idx <= scan_idx;
                    ptr      <= ptr + 1'b1;
                    if (ptr == LAST_IDX) begin
                        state    <= OUT;
                        tvalid_q <= 1'b1;
                        tdata_q  <= C_M00_AXIS_TDATA_WIDTH'(scan_idx);
                        max_sum  <= scan_best;
                    end
                end
                OUT: begin
                    if (m00_axis.tready) begin
                        state    <= IDLE;
                        tvalid_q <= 1'b0;
                        busy     <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_tm_argmax_sequencer.sv
// Directed bench for tm_argmax_sequencer: a 10-class and a 1-class instance.
module tb_tm_argmax_sequencer;

    logic clk;
    logic rst;

    logic signed [13:0] c10 [9:0];
    logic               t10;
    logic [13:0]        ms10;
    logic               busy10;
    logic [7:0]         drop10;

    logic signed [13:0] c1 [0:0];
    logic               t1;
    logic [13:0]        ms1;
    logic               busy1;
    logic [7:0]         drop1;

    int total = 0;
    int bad   = 0;

    tm_argmax_sequencer_if #(.TDATA_WIDTH(64)) ax10 ();
    tm_argmax_sequencer_if #(.TDATA_WIDTH(64)) ax1 ();

    tm_argmax_sequencer #(
        .CLASS_NUM(10), .WEIGHT_LENGTH(14), .C_M00_AXIS_TDATA_WIDTH(64), .DROP_CNT_WIDTH(8)
    ) u10 (
        .clk(clk), .rst(rst), .c_sum(c10), .its_business_time(t10),
        .m00_axis(ax10), .max_sum(ms10), .busy(busy10), .drop_cnt(drop10)
    );

    tm_argmax_sequencer #(
        .CLASS_NUM(1), .WEIGHT_LENGTH(14), .C_M00_AXIS_TDATA_WIDTH(64), .DROP_CNT_WIDTH(8)
    ) u1 (
        .clk(clk), .rst(rst), .c_sum(c1), .its_business_time(t1),
        .m00_axis(ax1), .max_sum(ms1), .busy(busy1), .drop_cnt(drop1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [13:0] w(input int v);
        return v[13:0];
    endfunction

    task automatic set10(input int v [10]);
        for (int i = 0; i < 10; i++) c10[i] = v[i];
    endtask

    int basic [10] = '{3, -1, 7, 2, 0, 7, -5, 1, 6, 4};
    int allmin [10] = '{-8192, -8192, -8192, -8192, -8192, -8192, -8192, -8192, -8192, -8192};
    int lastwin [10] = '{-8192, -8192, -8192, -8192, -8192, -8192, -8192, -8192, -8192, -8191};
    int junk [10] = '{100, 100, 100, 100, 100, 100, 100, 100, 100, 100};
    int cnt;

    initial begin
        rst = 1'b1;
        t10 = 1'b0;
        t1  = 1'b1;
        c1[0] = -14'sd3;
        ax10.tready = 1'b1;
        ax1.tready  = 1'b0;
        set10(basic);

        // Reset state
        tick();
        chk("rst_tvalid", ax10.tvalid, 0);
        chk("rst_tdata", ax10.tdata, 0);
        chk("rst_tlast", ax10.tlast, 0);
        chk("rst_max", ms10, 0);
        chk("rst_busy", busy10, 0);
        chk("rst_drop", drop10, 0);
        rst = 1'b0;

        // 1-class instance: level already high at release is a rising edge
        tick();
        chk("c1_tvalid", ax1.tvalid, 1);
        chk("c1_tdata", ax1.tdata, 0);
        chk("c1_max", ms1, w(-3));
        chk("c1_tlast", ax1.tlast, 1);
        ax1.tready = 1'b1;
        tick();
        chk("c1_hs_tvalid", ax1.tvalid, 0);
        chk("c1_hs_busy", busy1, 0);
        t1 = 1'b0;

        // Basic run with latency check
        t10 = 1'b1;
        tick();
        t10 = 1'b0;
        chk("basic_busy", busy10, 1);
        chk("basic_tvalid0", ax10.tvalid, 0);
        repeat (8) tick();
        chk("basic_early", ax10.tvalid, 0);
        tick();
        chk("basic_tvalid", ax10.tvalid, 1);
        chk("basic_tdata", ax10.tdata, 2);
        chk("basic_max", ms10, w(7));
        chk("basic_tlast", ax10.tlast, 1);
        tick();
        chk("basic_done_tvalid", ax10.tvalid, 0);
        chk("basic_done_tlast", ax10.tlast, 0);
        chk("basic_done_tdata", ax10.tdata, 2);
        chk("basic_done_busy", busy10, 0);

        // Backpressure, with c_sum corrupted one cycle after capture
        ax10.tready = 1'b0;
        t10 = 1'b1;
        tick();
        t10 = 1'b0;
        set10(junk);
        repeat (9) tick();
        for (int i = 0; i < 5; i++) begin
            chk("bp_tvalid", ax10.tvalid, 1);
            chk("bp_tdata", ax10.tdata, 2);
            chk("bp_max", ms10, w(7));
            tick();
        end
        chk("bp_still", ax10.tvalid, 1);
        ax10.tready = 1'b1;
        tick();
        chk("bp_hs_tvalid", ax10.tvalid, 0);
        chk("bp_hs_busy", busy10, 0);

        // Signed minimum everywhere: lowest index wins
        set10(allmin);
        t10 = 1'b1;
        tick();
        t10 = 1'b0;
        repeat (9) tick();
        chk("min_tvalid", ax10.tvalid, 1);
        chk("min_tdata", ax10.tdata, 0);
        chk("min_max", ms10, w(-8192));
        tick();

        set10(lastwin);
        t10 = 1'b1;
        tick();
        t10 = 1'b0;
        repeat (9) tick();
        chk("last_tvalid", ax10.tvalid, 1);
        chk("last_tdata", ax10.tdata, 9);
        chk("last_max", ms10, w(-8191));
        tick();

        // Dropped triggers in SCAN and OUT
        set10(basic);
        ax10.tready = 1'b0;
        t10 = 1'b1;
        tick();
        t10 = 1'b0;
        tick();
        t10 = 1'b1;
        tick();
        t10 = 1'b0;
        repeat (7) tick();
        chk("drop_scan_tvalid", ax10.tvalid, 1);
        chk("drop_scan_cnt", drop10, 1);
        t10 = 1'b1;
        tick();
        t10 = 1'b0;
        tick();
        chk("drop_out_tvalid", ax10.tvalid, 1);
        chk("drop_out_tdata", ax10.tdata, 2);
        chk("drop_out_cnt", drop10, 2);
        ax10.tready = 1'b1;
        tick();
        chk("drop_hs_tvalid", ax10.tvalid, 0);
        cnt = 0;
        repeat (12) begin
            tick();
            if (ax10.tvalid) cnt++;
        end
        chk("drop_no_extra", cnt, 0);
        chk("drop_idle_busy", busy10, 0);

        t10 = 1'b1;
        tick();
        t10 = 1'b0;
        repeat (9) tick();
        chk("fresh_tvalid", ax10.tvalid, 1);
        chk("fresh_tdata", ax10.tdata, 2);
        t10 = 1'b1;
        tick();
        t10 = 1'b0;
        chk("hs_drop_tvalid", ax10.tvalid, 0);
        chk("hs_drop_cnt", drop10, 3);
        repeat (10) tick();
        chk("hs_drop_busy", busy10, 0);

        // Level held high: one run only
        t10 = 1'b1;
        cnt = 0;
        repeat (30) begin
            tick();
            if (ax10.tvalid) cnt++;
        end
        chk("level_runs", cnt, 1);
        chk("level_busy", busy10, 0);
        t10 = 1'b0;
        tick();

        // Async reset mid-SCAN at ptr = 4
        t10 = 1'b1;
        tick();
        t10 = 1'b0;
        repeat (3) tick();
        chk("ar_busy_pre", busy10, 1);
        #2 rst = 1'b1;
        #1;
        chk("ar_tvalid", ax10.tvalid, 0);
        chk("ar_busy", busy10, 0);
        chk("ar_drop", drop10, 0);
        chk("ar_tdata", ax10.tdata, 0);
        @(posedge clk);
        #1 rst = 1'b0;
        cnt = 0;
        repeat (15) begin
            tick();
            if (ax10.tvalid) cnt++;
        end
        chk("ar_no_beat", cnt, 0);
        chk("ar_idle_busy", busy10, 0);

        // 1-class instance again, with the signed minimum
        ax1.tready = 1'b0;
        c1[0] = 14'h2000;
        t1 = 1'b1;
        tick();
        t1 = 1'b0;
        chk("c1b_tvalid", ax1.tvalid, 1);
        chk("c1b_tdata", ax1.tdata, 0);
        chk("c1b_max", ms1, w(-8192));
        chk("c1b_busy", busy1, 1);
        ax1.tready = 1'b1;
        tick();
        chk("c1b_hs", ax1.tvalid, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
